// File: rtl/axi4_sram_slave.sv
// AXI4 slave front end for a single-port synchronous SRAM: one burst at a time,
// fair read/write arbitration, and a 2-entry read buffer that absorbs rready stalls.
module axi4_sram_slave #(
  parameter int A  = 32,
  parameter int N  = 4,
  parameter int I  = 1,
  localparam int B  = $clog2(N),
  localparam int MW = A - B
) (
  input  logic           aclk,
  input  logic           areset,
  // AR channel
  input  logic [I-1:0]   arid,
  input  logic [A-1:0]   araddr,
  input  logic [7:0]     arlen,
  input  logic [2:0]     arsize,
  input  logic [1:0]     arburst,
  input  logic [3:0]     arcache,
  input  logic           arlock,
  input  logic [2:0]     arprot,
  input  logic [3:0]     arqos,
  input  logic [3:0]     arregion,
  input  logic           arvalid,
  output logic           arready,
  // AW channel
  input  logic [I-1:0]   awid,
  input  logic [A-1:0]   awaddr,
  input  logic [7:0]     awlen,
  input  logic [2:0]     awsize,
  input  logic [1:0]     awburst,
  input  logic [3:0]     awcache,
  input  logic           awlock,
  input  logic [2:0]     awprot,
  input  logic [3:0]     awqos,
  input  logic [3:0]     awregion,
  input  logic           awvalid,
  output logic           awready,
  // W channel
  input  logic [I-1:0]   wid,
  input  logic [8*N-1:0] wdata,
  input  logic [N-1:0]   wstrb,
  input  logic           wlast,
  input  logic           wvalid,
  output logic           wready,
  // B channel
  output logic [I-1:0]   bid,
  output logic [1:0]     bresp,
  output logic           bvalid,
  input  logic           bready,
  // R channel
  output logic [I-1:0]   rid,
  output logic [8*N-1:0] rdata,
  output logic [1:0]     rresp,
  output logic           rlast,
  output logic           rvalid,
  input  logic           rready,
  // SRAM port
  output logic           mem_en,
  output logic [N-1:0]   mem_we,
  output logic [MW-1:0]  mem_addr,
  output logic [8*N-1:0] mem_wdata,
  input  logic [8*N-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t          state, state_nxt;
  logic            last_grant_wr;
  logic [I-1:0]    id_q;
  logic [MW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [1:0]      burst_q;
  logic [8:0]      beat_cnt;
  logic [8:0]      ret_cnt;
  logic            inflight;
  logic [8*N-1:0]  fifo_mem [2];
  logic            fifo_wp, fifo_rp;
  logic [1:0]      fifo_count;

  logic            err_burst;
  logic            grant_rd;
  logic            w_hs;
  logic            pop;
  logic [2:0]      occ;
  logic            rd_issue;
  logic            unused_inputs;

  assign unused_inputs = ^{arsize, arcache, arlock, arprot, arqos, arregion, araddr,
                           awsize, awcache, awlock, awprot, awqos, awregion, awaddr,
                           wid, wlast};

  assign err_burst = (burst_q == 2'b11);
  assign grant_rd  = arvalid & (~awvalid | last_grant_wr);
  assign w_hs      = (state == WRITE) & wvalid;

  assign rvalid = (fifo_count != 2'd0);
  assign rdata  = fifo_mem[fifo_rp];
  assign rlast  = rvalid & (ret_cnt == {1'b0, len_q});
  assign rid    = id_q;
  assign rresp  = err_burst ? 2'b10 : 2'b00;
  assign bid    = id_q;
  assign bresp  = err_burst ? 2'b10 : 2'b00;
  assign pop    = rvalid & rready;

  // A read may issue only if the buffer will still have room when its data returns.
  assign occ      = {1'b0, fifo_count} + {2'b00, inflight};
  assign rd_issue = (state == READ) & ~areset & (beat_cnt <= {1'b0, len_q}) &
                    ((occ - {2'b00, pop}) < 3'd2);

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (!areset) begin
          arready = arvalid & grant_rd;
          awready = awvalid & ~grant_rd;
          if (arready)      state_nxt = READ;
          else if (awready) state_nxt = WRITE;
        end
      end
      WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_en    = ~err_burst & ~areset;
          mem_we    = (~err_burst & ~areset) ? wstrb : '0;
          mem_addr  = addr_q;
          mem_wdata = wdata;
          if (beat_cnt == {1'b0, len_q}) state_nxt = WRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      READ: begin
        if (rd_issue) begin
          mem_en   = ~err_burst;
          mem_addr = addr_q;
        end
        if (pop && rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst context, beat counters and the read buffer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant_wr <= 1'b0;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      burst_q       <= '0;
      beat_cnt      <= '0;
      ret_cnt       <= '0;
      inflight      <= 1'b0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      fifo_count    <= '0;
    end else begin
      if (arready) begin
        id_q          <= arid;
        addr_q        <= araddr[A-1:B];
        len_q         <= arlen;
        burst_q       <= arburst;
        last_grant_wr <= 1'b0;
        beat_cnt      <= '0;
        ret_cnt       <= '0;
      end else if (awready) begin
        id_q          <= awid;
        addr_q        <= awaddr[A-1:B];
        len_q         <= awlen;
        burst_q       <= awburst;
        last_grant_wr <= 1'b1;
        beat_cnt      <= '0;
        ret_cnt       <= '0;
      end
      if (w_hs || rd_issue) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (burst_q != 2'b00) addr_q <= addr_q + MW'(1);
      end
      inflight <= rd_issue;
      if (inflight) begin
        fifo_mem[fifo_wp] <= err_burst ? '0 : mem_rdata;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) begin
        ret_cnt <= ret_cnt + 9'd1;
        fifo_rp <= ~fifo_rp;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed self-checking bench for axi4_sram_slave with a behavioural SRAM model.
module tb_axi4_sram_slave;

  localparam int A = 32;
  localparam int N = 4;
  localparam int I = 1;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [I-1:0] arid, awid, bid, rid;
  logic [31:0]  araddr, awaddr;
  logic [7:0]   arlen, awlen;
  logic [1:0]   arburst, awburst, bresp, rresp;
  logic         arvalid, arready, awvalid, awready;
  logic [31:0]  wdata, rdata, mem_wdata, mem_rdata;
  logic [3:0]   wstrb, mem_we;
  logic         wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready, mem_en;
  logic [29:0]  mem_addr;

  axi4_sram_slave #(.A(A), .N(N), .I(I)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(3'd2), .arburst(arburst),
    .arcache(4'd0), .arlock(1'b0), .arprot(3'd0), .arqos(4'd0), .arregion(4'd0),
    .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(3'd2), .awburst(awburst),
    .awcache(4'd0), .awlock(1'b0), .awprot(3'd0), .awqos(4'd0), .awregion(4'd0),
    .awvalid(awvalid), .awready(awready),
    .wid(1'b0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM model: word i is preloaded with 0xC0DE0000 | i; every access is logged.
  logic [31:0] sram [256];
  bit          preloaded = 1'b0;
  int          acc_cnt = 0;
  logic [29:0] acc_addr [$];
  logic [3:0]  acc_we [$];

  always @(posedge aclk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) sram[i] = 32'hC0DE_0000 | i;
      preloaded = 1'b1;
    end
    if (mem_en) begin
      acc_cnt++;
      acc_addr.push_back(mem_addr);
      acc_we.push_back(mem_we);
      if (mem_we != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) sram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[7:0]];
      end
    end
  end

  int          checks = 0;
  int          failures = 0;

  logic [31:0] wb_data [8];
  logic [3:0]  wb_strb [8];
  bit          rr_pat [16];
  logic [31:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic        rb_last [16];
  logic [I-1:0] rb_id [16];
  int          rb_n, first_rv, stall_err, fifo_max;
  int          abort_beat = -1;
  logic [1:0]  b_resp;
  logic [I-1:0] b_id;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyReset();
    areset = 1'b1;
    arvalid = 0; awvalid = 0; wvalid = 0; bready = 0; rready = 0; wlast = 0;
    arid = 0; awid = 0; araddr = 0; awaddr = 0; arlen = 0; awlen = 0;
    arburst = 2'b01; awburst = 2'b01; wdata = 0; wstrb = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
  endtask

  // Runs one complete burst; write data comes from wb_*, read beats land in rb_*.
  task automatic applyStimulus(input bit is_read, input logic [I-1:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [1:0] burst);
    bit ok, done, aborted, prev_stall;
    int pidx, a1;
    logic [31:0] prev_data;
    logic [1:0]  prev_resp;
    @(negedge aclk);
    if (is_read) begin
      arvalid = 1; arid = id; araddr = addr; arlen = len; arburst = burst;
    end else begin
      awvalid = 1; awid = id; awaddr = addr; awlen = len; awburst = burst;
    end
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (is_read ? arready : awready) ok = 1;
      else @(negedge aclk);
    end
    checkOutput("addr_handshake", ok, 1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    if (!is_read) begin
      for (int i = 0; i <= len; i++) begin
        wvalid = 1; wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = (i == len);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
          #1;
          if (wready) ok = 1;
          else @(negedge aclk);
        end
        if (!ok) begin
          checkOutput("wready_wait", ok, 1);
          break;
        end
        @(posedge aclk);
        @(negedge aclk);
      end
      wvalid = 0; wlast = 0; bready = 1;
      #1;
      checkOutput("bvalid_after_last_w", bvalid, 1);
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
        if (bvalid) ok = 1;
        else begin @(negedge aclk); #1; end
      end
      checkOutput("bvalid_wait", ok, 1);
      b_resp = bresp; b_id = bid;
      @(posedge aclk);
      @(negedge aclk);
      bready = 0;
    end else begin
      rb_n = 0; first_rv = -1; pidx = 0; prev_stall = 0; done = 0; aborted = 0;
      prev_data = 0; prev_resp = 0;
      for (int k = 1; k < 200 && !done; k++) begin
        #1;
        if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
        if (prev_stall && !rvalid) stall_err++;
        if (rvalid) begin
          if (first_rv < 0) first_rv = k;
          if (prev_stall && (rdata !== prev_data || rresp !== prev_resp)) stall_err++;
          if (abort_beat == rb_n) begin
            areset = 1; arvalid = 1; araddr = 0; arlen = 0; arburst = 2'b01; rready = 0;
            a1 = acc_cnt;
            @(posedge aclk);
            @(negedge aclk);
            #1;
            checkOutput("rst_rvalid", rvalid, 0);
            checkOutput("rst_arready", arready, 0);
            checkOutput("rst_mem_en", mem_en, 0);
            @(posedge aclk);
            @(negedge aclk);
            areset = 0; arvalid = 0;
            checkOutput("rst_no_access", acc_cnt - a1, 0);
            aborted = 1;
            break;
          end
          rready = (pidx < 16) ? rr_pat[pidx] : 1'b1;
          pidx++;
          prev_stall = !rready; prev_data = rdata; prev_resp = rresp;
          if (rready && rb_n < 16) begin
            rb_data[rb_n] = rdata; rb_resp[rb_n] = rresp; rb_last[rb_n] = rlast; rb_id[rb_n] = rid;
            rb_n++;
            if (rlast) done = 1;
          end
        end else begin
          rready = 0;
          prev_stall = 0;
        end
        @(posedge aclk);
        @(negedge aclk);
      end
      rready = 0;
      if (!aborted) checkOutput("read_done", done, 1);
    end
  endtask

  // Offers a len-0 read and write together and reports which one was granted.
  task automatic arbRound(output bit got_read);
    bit ok;
    @(negedge aclk);
    arvalid = 1; awvalid = 1; arid = 0; awid = 0; araddr = 32'h80; awaddr = 32'h80;
    arlen = 0; awlen = 0; arburst = 2'b01; awburst = 2'b01;
    #1;
    got_read = arready;
    checkOutput("arb_one_ready", arready ^ awready, 1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0; awvalid = 0;
    ok = 0;
    if (got_read) begin
      rready = 1;
      for (int k = 0; k < 20 && !ok; k++) begin
        #1;
        if (rvalid) ok = 1;
        else @(negedge aclk);
      end
      @(posedge aclk);
      @(negedge aclk);
      rready = 0;
    end else begin
      wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wlast = 1;
      #1;
      @(posedge aclk);
      @(negedge aclk);
      wvalid = 0; wlast = 0; bready = 1;
      for (int k = 0; k < 20 && !ok; k++) begin
        #1;
        if (bvalid) ok = 1;
        else @(negedge aclk);
      end
      @(posedge aclk);
      @(negedge aclk);
      bready = 0;
    end
    checkOutput("arb_response", ok, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0;
    bit g1, g2, g3;
    fifo_max = 0;
    stall_err = 0;
    for (int i = 0; i < 16; i++) rr_pat[i] = 1'b1;

    applyReset();
    #1;
    checkOutput("reset_arready", arready, 0);
    checkOutput("reset_awready", awready, 0);
    checkOutput("reset_wready", wready, 0);
    checkOutput("reset_bvalid", bvalid, 0);
    checkOutput("reset_rvalid", rvalid, 0);
    checkOutput("reset_rlast", rlast, 0);
    checkOutput("reset_mem_en", mem_en, 0);
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_rdata", rdata, 0);
    checkOutput("reset_resps", {bresp, rresp}, 0);
    areset = 0;

    $display("[TB] single write then single read");
    wb_data[0] = 32'hA5A5_5A5A; wb_strb[0] = 4'hF;
    a0 = acc_cnt;
    applyStimulus(0, 1'b1, 32'h10, 8'd0, 2'b01);
    checkOutput("w1_accesses", acc_cnt - a0, 1);
    checkOutput("w1_mem_addr", acc_addr[a0], 4);
    checkOutput("w1_mem_we", acc_we[a0], 4'hF);
    checkOutput("w1_bresp", b_resp, 2'b00);
    checkOutput("w1_bid", b_id, 1);
    applyStimulus(1, 1'b0, 32'h10, 8'd0, 2'b01);
    checkOutput("r1_beats", rb_n, 1);
    checkOutput("r1_rdata", rb_data[0], 32'hA5A5_5A5A);
    checkOutput("r1_rlast", rb_last[0], 1);
    checkOutput("r1_rresp", rb_resp[0], 2'b00);
    checkOutput("r1_rid", rb_id[0], 0);
    checkOutput("r1_first_rvalid", first_rv, 3);

    $display("[TB] INCR read with back-pressure");
    rr_pat[1] = 1'b0; rr_pat[2] = 1'b0;
    fifo_max = 0; stall_err = 0;
    a0 = acc_cnt;
    applyStimulus(1, 1'b1, 32'h20, 8'd3, 2'b01);
    for (int i = 0; i < 16; i++) rr_pat[i] = 1'b1;
    checkOutput("incr_beats", rb_n, 4);
    checkOutput("incr_d0", rb_data[0], 32'hC0DE_0008);
    checkOutput("incr_d1", rb_data[1], 32'hC0DE_0009);
    checkOutput("incr_d2", rb_data[2], 32'hC0DE_000A);
    checkOutput("incr_d3", rb_data[3], 32'hC0DE_000B);
    checkOutput("incr_rlast", {rb_last[0], rb_last[1], rb_last[2], rb_last[3]}, 4'b0001);
    checkOutput("incr_rid", rb_id[3], 1);
    checkOutput("incr_accesses", acc_cnt - a0, 4);
    checkOutput("incr_addrs", {acc_addr[a0][7:0], acc_addr[a0+1][7:0], acc_addr[a0+2][7:0],
                               acc_addr[a0+3][7:0]}, 32'h08090A0B);
    checkOutput("incr_fifo_max", fifo_max, 2);
    checkOutput("incr_stable", stall_err, 0);

    $display("[TB] FIXED write with partial strobes");
    wb_data[0] = 32'h1111_1111; wb_strb[0] = 4'h1;
    wb_data[1] = 32'h2222_2222; wb_strb[1] = 4'h2;
    wb_data[2] = 32'h3333_3333; wb_strb[2] = 4'hC;
    a0 = acc_cnt;
    applyStimulus(0, 1'b0, 32'h40, 8'd2, 2'b00);
    checkOutput("fixed_accesses", acc_cnt - a0, 3);
    checkOutput("fixed_addrs", {acc_addr[a0][7:0], acc_addr[a0+1][7:0], acc_addr[a0+2][7:0]},
                24'h101010);
    checkOutput("fixed_we", {acc_we[a0], acc_we[a0+1], acc_we[a0+2]}, 12'h12C);
    checkOutput("fixed_word", sram[16], 32'h3333_2211);
    checkOutput("fixed_bresp", b_resp, 2'b00);

    $display("[TB] arbitration");
    applyReset();
    areset = 0;
    arbRound(g1);
    arbRound(g2);
    arbRound(g3);
    checkOutput("arb_order", {g1, g2, g3}, 3'b010);

    $display("[TB] reserved burst");
    wb_data[0] = 32'hFFFF_FFFF; wb_strb[0] = 4'hF;
    wb_data[1] = 32'hFFFF_FFFF; wb_strb[1] = 4'hF;
    a0 = acc_cnt;
    applyStimulus(0, 1'b0, 32'h30, 8'd1, 2'b11);
    checkOutput("rsv_w_accesses", acc_cnt - a0, 0);
    checkOutput("rsv_bresp", b_resp, 2'b10);
    checkOutput("rsv_word_kept", sram[12], 32'hC0DE_000C);
    a0 = acc_cnt;
    applyStimulus(1, 1'b0, 32'h20, 8'd1, 2'b11);
    checkOutput("rsv_r_accesses", acc_cnt - a0, 0);
    checkOutput("rsv_beats", rb_n, 2);
    checkOutput("rsv_rdata", {rb_data[0], rb_data[1]}, 64'h0);
    checkOutput("rsv_rresp", {rb_resp[0], rb_resp[1]}, 4'b1010);
    checkOutput("rsv_rlast", {rb_last[0], rb_last[1]}, 2'b01);

    $display("[TB] reset mid-read");
    abort_beat = 1;
    applyStimulus(1, 1'b0, 32'h20, 8'd7, 2'b01);
    abort_beat = -1;
    checkOutput("abort_beat0", rb_data[0], 32'hC0DE_0008);
    applyStimulus(1, 1'b1, 32'h24, 8'd1, 2'b01);
    checkOutput("fresh_beats", rb_n, 2);
    checkOutput("fresh_d0", rb_data[0], 32'hC0DE_0009);
    checkOutput("fresh_d1", rb_data[1], 32'hC0DE_000A);
    checkOutput("fresh_rlast", {rb_last[0], rb_last[1]}, 2'b01);
    checkOutput("fresh_first_rvalid", first_rv, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
